// File: rtl/kf_ir_frame_tx.sv
// FIFO-buffered IR frame transmitter: leader bits, data LSB-first, optional even parity, stop bit, bi-phase coded.
// Optional parity bit is enabled by defining KF_IR_PARITY_EN.
module kf_ir_frame_tx #(
    parameter int          DATA_WIDTH      = 8,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] BIT_PHASE_CYCLE = 16'd21999,
    parameter int          LEADER_BITS     = 1,
    parameter int          GAP_BITS        = 2,
    parameter int          REPEAT_COUNT    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  ir_signal
);

`ifdef KF_IR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int          NBITS = LEADER_BITS + DATA_WIDTH + PAR_BITS + 1;
    localparam int          BCW   = $clog2(NBITS + 1);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF  = BIT_PHASE_CYCLE >> 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Frame image, sent from bit 0 upwards: leader ones, data, [parity], stop.
    function automatic logic [NBITS-1:0] frame_of(input logic [DATA_WIDTH-1:0] word);
        logic [NBITS-1:0] f;
        f = '1;
        f[LEADER_BITS +: DATA_WIDTH] = word;
`ifdef KF_IR_PARITY_EN
        f[LEADER_BITS + DATA_WIDTH] = ^word;
`endif
        return f;
    endfunction

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]           level_reg;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] rd_word;

    assign full     = (level_reg == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level_reg == '0);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign rd_word  = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ---------------- Free-running bit-phase counter ----------------
    logic [15:0] cnt_reg;
    logic        boundary, first_half;

    assign boundary   = (cnt_reg == 16'd0);
    assign first_half = (cnt_reg > HALF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= BIT_PHASE_CYCLE;
        end else if (boundary) begin
            cnt_reg <= BIT_PHASE_CYCLE;
        end else begin
            cnt_reg <= cnt_reg - 16'd1;
        end
    end

    // ---------------- Framing FSM ----------------
    state_t                state_reg, state_next;
    logic [NBITS-1:0]      shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] word_reg, word_next;
    logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [3:0]            gap_cnt_reg, gap_cnt_next;
    logic [2:0]            rep_reg, rep_next;
    logic                  done_next, frame_end, try_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '1;
            word_reg    <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            rep_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            word_reg    <= word_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            rep_reg     <= rep_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        word_next    = word_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        rep_next     = rep_reg;
        pop          = 1'b0;
        done_next    = 1'b0;
        frame_end    = 1'b0;
        try_pop      = 1'b0;
        if (boundary) begin
            case (state_reg)
                IDLE: try_pop = 1'b1;
                SEND: begin
                    if (bit_cnt_reg == BCW'(NBITS - 1)) begin
                        done_next = 1'b1;
                        if (GAP_BITS == 0) begin
                            frame_end = 1'b1;
                        end else begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + BCW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == 4'(GAP_BITS - 1)) begin
                        frame_end = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase

            // A finished frame either repeats the held word or falls through to the
            // idle check, so a queued word starts on the same boundary.
            if (frame_end && (rep_reg != 3'd0)) begin
                rep_next     = rep_reg - 3'd1;
                shift_next   = frame_of(word_reg);
                bit_cnt_next = '0;
                state_next   = SEND;
            end else if (frame_end || try_pop) begin
                if (!empty) begin
                    pop          = 1'b1;
                    word_next    = rd_word;
                    shift_next   = frame_of(rd_word);
                    rep_next     = 3'(REPEAT_COUNT);
                    bit_cnt_next = '0;
                    state_next   = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
        end
    end

    // ---------------- Outputs ----------------
    assign busy = (state_reg != IDLE) | ~empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_signal  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_next;
            if (state_reg == SEND) begin
                ir_signal <= first_half ? ~shift_reg[0] : shift_reg[0];
            end else begin
                ir_signal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kf_ir_frame_tx.sv
// Directed bench for kf_ir_frame_tx: table of words with hand-computed bit sequences, plus backpressure,
// boundary-push, repeat and mid-frame reset sequences.
module tb_kf_ir_frame_tx;

    localparam logic [15:0] BPC = 16'd9;
    localparam int P = 10;
`ifdef KF_IR_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FP   = P * NB + 2 * P;
    localparam int MAXC = 8000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] in_data_a = 8'h00, in_data_b = 8'h00;
    logic in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic in_ready_a, busy_a, frame_done_a, ir_a;
    logic in_ready_b, busy_b, frame_done_b, ir_b;

    always #5 clock = ~clock;

    kf_ir_frame_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_PHASE_CYCLE(BPC),
                     .LEADER_BITS(1), .GAP_BITS(2), .REPEAT_COUNT(0)) dut_a (
        .clock(clock), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .busy(busy_a), .frame_done(frame_done_a), .ir_signal(ir_a));

    kf_ir_frame_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_PHASE_CYCLE(BPC),
                     .LEADER_BITS(1), .GAP_BITS(2), .REPEAT_COUNT(2)) dut_b (
        .clock(clock), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .busy(busy_b), .frame_done(frame_done_b), .ir_signal(ir_b));

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 sent first: leader, data LSB-first, stop
        logic       par;
    } vec_t;

    vec_t vt[6];
    int k, tests, fails;
    logic log_ir [2][MAXC];
    logic log_fd [2][MAXC];

    // Cycle-indexed capture; k is the sample index since the last reset release.
    always @(negedge clock) begin
        if (k >= 0 && k < MAXC) begin
            log_ir[0][k] = ir_a;
            log_fd[0][k] = frame_done_a;
            log_ir[1][k] = ir_b;
            log_fd[1][k] = frame_done_b;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic check1(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", nm, got);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] d, output int acc);
        int w;
        w = 0;
        if (sel == 0) begin in_data_a = d; in_valid_a = 1'b1; end
        else          begin in_data_b = d; in_valid_b = 1'b1; end
        while (!((sel == 0) ? in_ready_a : in_ready_b) && w < 4000) begin
            tick();
            w++;
        end
        if (w >= 4000) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1");
            acc = -1;
        end else begin
            acc = k;
        end
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    function automatic logic [15:0] seq_of(input vec_t v);
        logic [15:0] s;
        s = '0;
        s[8:0] = v.frame[8:0];
`ifdef KF_IR_PARITY_EN
        s[9]  = v.par;
        s[10] = 1'b1;
`else
        s[9]  = v.frame[9];
`endif
        return s;
    endfunction

    // Push accepted at sample acc; popped at the first later boundary b; leader low at b+2.
    function automatic int next_fall(input int acc);
        int b;
        b = acc + 1;
        while (b % P != P - 1) b++;
        return b + 2;
    endfunction

    task automatic check_frame(input int sel, input int f, input vec_t v, input string nm);
        logic [15:0] s;
        logic [9:0]  got, exp;
        int nfd, nbad;
        s = seq_of(v);
        if (f < 1 || f + NB * P + 2 * P >= MAXC) begin
            tests++;
            fails++;
            $display("FAIL %s_window: start %0d out of capture range", nm, f);
            return;
        end
        check1($sformatf("%s_lead_edge", nm), 32'(log_ir[sel][f-1]), 32'd1);
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < P; i++) got[i] = log_ir[sel][f + j * P + i];
            exp = s[j] ? 10'b1111100000 : 10'b0000011111;
            check1($sformatf("%s_bit%0d", nm, j), 32'(got), 32'(exp));
        end
        nfd = 0;
        for (int c = f; c < f + NB * P - 1; c++) if (log_fd[sel][c]) nfd++;
        check1($sformatf("%s_fd_early", nm), 32'(nfd), 32'd0);
        check1($sformatf("%s_fd_pulse", nm), 32'(log_fd[sel][f + NB * P - 1]), 32'd1);
        nbad = 0;
        for (int c = f + NB * P; c < f + NB * P + 2 * P; c++)
            if (!log_ir[sel][c] || log_fd[sel][c]) nbad++;
        check1($sformatf("%s_gap", nm), 32'(nbad), 32'd0);
    endtask

    initial begin
        int acc[6];
        int f0, a0, a1, fb, nfd, nbad;
        k = 0;
        tests = 0;
        fails = 0;
        vt[0] = '{8'hA5, 10'b1101001011, 1'b0};
        vt[1] = '{8'h3C, 10'b1001111001, 1'b0};
        vt[2] = '{8'h01, 10'b1000000011, 1'b1};
        vt[3] = '{8'h80, 10'b1100000001, 1'b1};
        vt[4] = '{8'hF0, 10'b1111100001, 1'b0};
        vt[5] = '{8'h00, 10'b1000000001, 1'b0};

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check1("rst_ir_a", 32'(ir_a), 32'd1);
        check1("rst_fd_a", 32'(frame_done_a), 32'd0);
        check1("rst_busy_a", 32'(busy_a), 32'd0);
        check1("rst_ir_b", 32'(ir_b), 32'd1);
        reset = 1'b0;
        k = 0;
        check1("rel_ready_a", 32'(in_ready_a), 32'd1);
        check1("rel_busy_a", 32'(busy_a), 32'd0);

        // Table run with backpressure: six words back-to-back into a 4-deep FIFO
        while (k % P != 0) tick();
        for (int i = 0; i < 6; i++) push(0, vt[i].data, acc[i]);
        check1("busy_active", 32'(busy_a), 32'd1);
        check1("bp_accept4", 32'(acc[3]), 32'(acc[0] + 3));
        check1("bp_accept5", 32'(acc[4]), 32'(acc[0] + P));
        check1("bp_accept6", 32'(acc[5]), 32'(acc[0] + P + FP));
        f0 = next_fall(acc[0]);
        run_to(f0 + 6 * FP + 5);
        for (int i = 0; i < 6; i++) check_frame(0, f0 + i * FP, vt[i], $sformatf("tbl%0d", i));
        check1("bp_busy_end", 32'(busy_a), 32'd0);

        // Push on the very boundary where IDLE sees an empty FIFO
        while (k % P != P - 1) tick();
        push(0, vt[1].data, a0);
        check1("sim_push_at_boundary", 32'(a0 % P), 32'(P - 1));
        run_to(a0 + 12 + FP + 5);
        check1("sim_not_early", 32'(log_ir[0][a0 + 2]), 32'd1);
        check_frame(0, a0 + 12, vt[1], "sim");

        // Repeat instance: three copies of 3C, then the next word
        push(1, vt[1].data, a0);
        push(1, vt[2].data, a1);
        fb = next_fall(a0);
        run_to(fb + 4 * FP + 5);
        for (int r = 0; r < 3; r++) check_frame(1, fb + r * FP, vt[1], $sformatf("rep%0d", r));
        check_frame(1, fb + 3 * FP, vt[2], "rep_next");
        nfd = 0;
        for (int c = fb; c < fb + 3 * FP; c++) if (log_fd[1][c]) nfd++;
        check1("rep_fd_count", 32'(nfd), 32'd3);

        // Reset mid-frame with words still queued
        for (int i = 0; i < 4; i++) push(0, vt[i].data, acc[i]);
        repeat (150) tick();
        reset = 1'b1;
        #1;
        check1("rstmid_ir", 32'(ir_a), 32'd1);
        check1("rstmid_ready", 32'(in_ready_a), 32'd1);
        repeat (2) tick();
        reset = 1'b0;
        k = 0;
        check1("rstrel_busy", 32'(busy_a), 32'd0);
        check1("rstrel_ir", 32'(ir_a), 32'd1);
        run_to(400);
        nbad = 0;
        for (int c = 0; c < 400; c++) if (!log_ir[0][c] || log_fd[0][c]) nbad++;
        check1("rst_quiet", 32'(nbad), 32'd0);
        check1("rst_quiet_busy", 32'(busy_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
